// File: rtl/line_buffer_stream_pkg.sv
// Shared helpers for the line buffer and the MAC array: LOG2, counter widths, window bit offsets.
// Padding support is selected in the other files by LINE_BUFFER_ZERO_PAD_EN.
`ifndef LOG2
`define LOG2(x) ($clog2(x))
`endif

package line_buffer_stream_pkg;

  // Counters never get narrower than one bit, even for a single-entry range.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : `LOG2(n);
  endfunction

  function automatic int win_offset(input int k, input int i, input int j, input int pix_width);
    return pix_width * (k * i + j);
  endfunction

endpackage

// File: rtl/block_ram.sv
// Single-port RAM with synchronous write and asynchronous read, so a location can be read
// and overwritten in the same cycle (read returns the old contents).
module block_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH < 2) ? 1 : $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer_pos_ctrl.sv
// Raster position tracking for line_buffer_stream: col/row counters, shared memory pointer,
// window gating and frame end. LINE_BUFFER_ZERO_PAD_EN adds flush bubbles and the zero mask.
module line_buffer_pos_ctrl
  import line_buffer_stream_pkg::*;
#(
  parameter int FILTER_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int PAD          = 0,
  parameter int PW           = cnt_width(IMAGE_WIDTH + PAD - FILTER_SIZE + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             step,
  output logic [PW-1:0]                    ptr,
  output logic                             window_hit,
  output logic                             frame_last,
  output logic                             flush,
  output logic [FILTER_SIZE*FILTER_SIZE-1:0] zero_mask
);

  // Positions beyond the real image are bubble slots used only when padding is enabled.
  localparam int COLS  = IMAGE_WIDTH + PAD;
  localparam int ROWS  = IMAGE_HEIGHT + PAD;
  localparam int DEPTH = COLS - (FILTER_SIZE - 1);
  localparam int CW    = cnt_width(COLS);
  localparam int RW    = cnt_width(ROWS);
  localparam int FIRST = FILTER_SIZE - 1 - PAD;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_end;
  logic          row_end;
  logic          ptr_end;

  assign col_end = (col == CW'(COLS - 1));
  assign row_end = (row == RW'(ROWS - 1));
  assign ptr_end = (ptr == PW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      ptr <= '0;
    end else if (step) begin
      col <= col_end ? '0 : col + CW'(1);
      if (col_end) row <= row_end ? '0 : row + RW'(1);
      ptr <= ptr_end ? '0 : ptr + PW'(1);
    end
  end

  assign window_hit = (col >= CW'(FIRST)) && (row >= RW'(FIRST));
  assign frame_last = col_end && row_end;

`ifdef LINE_BUFFER_ZERO_PAD_EN
  assign flush = (col >= CW'(IMAGE_WIDTH)) || (row >= RW'(IMAGE_HEIGHT));

  // Element (i,j) maps to image pixel (row-K+1+i, col-K+1+j); anything outside reads as zero.
  always_comb begin
    zero_mask = '0;
    for (int i = 0; i < FILTER_SIZE; i++) begin
      for (int j = 0; j < FILTER_SIZE; j++) begin
        zero_mask[FILTER_SIZE*i+j] = (int'(row) + i < FILTER_SIZE - 1) ||
                                     (int'(row) + i >= IMAGE_HEIGHT + FILTER_SIZE - 1) ||
                                     (int'(col) + j < FILTER_SIZE - 1) ||
                                     (int'(col) + j >= IMAGE_WIDTH + FILTER_SIZE - 1);
      end
    end
  end
`else
  assign flush     = 1'b0;
  assign zero_mask = '0;
`endif

endmodule

// File: rtl/line_buffer_stream.sv
// Streaming KxK sliding-window generator with valid/ready on both sides.
// Define LINE_BUFFER_ZERO_PAD_EN for "same" zero padding; the default build emits valid-mode windows.
module line_buffer_stream
  import line_buffer_stream_pkg::*;
#(
  parameter int FILTER_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28,
  parameter int D_WIDTH      = 8,
  parameter int CHANNELS     = 1
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                clk_en,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [D_WIDTH*CHANNELS-1:0]                         in_data,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [D_WIDTH*CHANNELS*FILTER_SIZE*FILTER_SIZE-1:0] out_window,
  output logic                                                out_last
);

  localparam int K   = FILTER_SIZE;
  localparam int PIX = D_WIDTH * CHANNELS;
`ifdef LINE_BUFFER_ZERO_PAD_EN
  localparam int PAD = (K - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int DEPTH = IMAGE_WIDTH + PAD - (K - 1);
  localparam int PW    = cnt_width(DEPTH);

  logic [PW-1:0]      ptr;
  logic               window_hit;
  logic               frame_last;
  logic               flush;
  logic [K*K-1:0]     zero_mask;
  logic               drain_ok;
  logic               accept;
  logic               step;
  logic [PIX-1:0]     chain_in;
  logic [PIX-1:0]     shreg [K][K-1];
  logic [PIX-1:0]     cur [K];
  logic [PIX*K*K-1:0] next_window;

  assign drain_ok = !out_valid || out_ready;
  assign in_ready = drain_ok && !flush;
  assign accept   = clk_en && in_valid && in_ready;

`ifdef LINE_BUFFER_ZERO_PAD_EN
  // Bubbles advance the line buffer like real pixels but inject zeros.
  assign step     = accept || (clk_en && flush && drain_ok);
  assign chain_in = flush ? '0 : in_data;
`else
  assign step     = accept;
  assign chain_in = in_data;
`endif

  line_buffer_pos_ctrl #(
    .FILTER_SIZE (FILTER_SIZE),
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .IMAGE_HEIGHT(IMAGE_HEIGHT),
    .PAD         (PAD)
  ) u_pos_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (step),
    .ptr       (ptr),
    .window_hit(window_hit),
    .frame_last(frame_last),
    .flush     (flush),
    .zero_mask (zero_mask)
  );

  // Each row is one long delay line: K-1 shift stages followed by a memory of the rest of the row.
  assign cur[K-1] = chain_in;

  for (genvar m = 0; m < K - 1; m++) begin : g_row_mem
    block_ram #(
      .DEPTH(DEPTH),
      .WIDTH(PIX)
    ) u_row_mem (
      .clk  (clk),
      .we   (step),
      .addr (ptr),
      .wdata(shreg[K-1-m][0]),
      .rdata(cur[K-2-m])
    );
  end

  always_ff @(posedge clk) begin
    if (step) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 2; j++) shreg[i][j] <= shreg[i][j+1];
        shreg[i][K-2] <= cur[i];
      end
    end
  end

  always_comb begin
    next_window = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K - 1; j++)
        next_window[win_offset(K, i, j, PIX) +: PIX] = zero_mask[K*i+j] ? '0 : shreg[i][j];
      next_window[win_offset(K, i, K-1, PIX) +: PIX] = zero_mask[K*i+K-1] ? '0 : cur[i];
    end
  end

  // A newly loaded window replaces one being handed off on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_window <= '0;
    end else if (clk_en) begin
      if (step && window_hit) begin
        out_valid  <= 1'b1;
        out_last   <= frame_last;
        out_window <= next_window;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_stream.sv
// Scoreboard bench for line_buffer_stream: K=3 on a 5x4 image, 3 channels of {idx+2, idx+1, idx}.
module tb_line_buffer_stream;

  localparam int K   = 3;
  localparam int W   = 5;
  localparam int H   = 4;
  localparam int DW  = 8;
  localparam int CH  = 3;
  localparam int PIX = DW * CH;
  localparam int WIN = PIX * K * K;

  typedef struct packed {
    logic [WIN-1:0] win;
    logic           last;
  } exp_t;

  logic           clk       = 1'b0;
  logic           rst_n     = 1'b1;
  logic           clk_en    = 1'b1;
  logic           in_valid  = 1'b0;
  logic           out_ready = 1'b1;
  logic           in_ready;
  logic           out_valid;
  logic           out_last;
  logic [PIX-1:0] in_data   = '0;
  logic [WIN-1:0] out_window;

  int             tests = 0;
  int             fails = 0;
  int             seen  = 0;
  int             lasts = 0;
  int             mode  = 0;
  int             cyc   = 0;
  exp_t           sb[$];
  exp_t           mon_e;
  logic           held_valid = 1'b0;
  logic [WIN-1:0] held_win   = '0;
  logic [WIN-1:0] first_win  = '0;

  line_buffer_stream #(
    .FILTER_SIZE (K),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .D_WIDTH     (DW),
    .CHANNELS    (CH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_window(out_window),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [PIX-1:0] pix(input int v);
    return {8'(v + 2), 8'(v + 1), 8'(v)};
  endfunction

  function automatic logic [WIN-1:0] expWin(input int base, input int r, input int c);
    logic [WIN-1:0] w;
    w = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        w[PIX*(K*i+j) +: PIX] = pix(base + (r - K + 1 + i) * W + (c - K + 1 + j));
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [WIN-1:0] act, input logic [WIN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends pixels 0..last_idx of a frame; expected windows are queued as each pixel is accepted.
  task automatic applyStimulus(input int base, input int last_idx);
    int   r;
    int   c;
    int   budget;
    bit   acc;
    exp_t e;
    for (int idx = 0; idx <= last_idx; idx++) begin
      r        = idx / W;
      c        = idx % W;
      in_valid = 1'b1;
      in_data  = pix(base + idx);
      acc      = 1'b0;
      budget   = 0;
      while (!acc && budget < 100) begin
        @(negedge clk);
        acc = clk_en && in_ready;
        if (acc && r >= K - 1 && c >= K - 1) begin
          e.win  = expWin(base, r, c);
          e.last = (r == H - 1) && (c == W - 1);
          sb.push_back(e);
        end
        @(posedge clk);
        #1;
        budget++;
      end
      if (!acc) begin
        tests++;
        fails++;
        $display("[TB] FAIL accept_timeout: pixel %0d still waiting after %0d cycles, required acceptance", idx, budget);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drainAndCount(input string name, input int want_windows, input int want_lasts);
    int budget = 0;
    while ((sb.size() != 0 || out_valid) && budget < 200) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput({name, "_drained"}, WIN'(sb.size()), '0);
    checkOutput({name, "_count"}, WIN'(seen), WIN'(want_windows));
    checkOutput({name, "_last"}, WIN'(lasts), WIN'(want_lasts));
    seen  = 0;
    lasts = 0;
  endtask

  // Consumer-side controls: free-running, toggling ready with periodic stalls, or blocked.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    case (mode)
      1: begin
        out_ready = cyc[0];
        clk_en    = (cyc % 4) != 3;
      end
      2: begin
        out_ready = 1'b0;
        clk_en    = 1'b1;
      end
      default: begin
        out_ready = 1'b1;
        clk_en    = 1'b1;
      end
    endcase
  end

  // Monitor: pops the scoreboard on each completed output handshake and checks stall behaviour.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        checkOutput("stall_valid", WIN'(out_valid), WIN'(1));
        checkOutput("stall_window", out_window, held_win);
      end
      if (out_valid && !out_ready) checkOutput("skid_in_ready", WIN'(in_ready), '0);
      if (out_valid && out_ready && clk_en) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_window: got %0h expected no window", out_window);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("window", out_window, mon_e.win);
          checkOutput("window_last", WIN'(out_last), WIN'(mon_e.last));
          if (seen == 0) first_win = out_window;
          seen++;
          if (out_last) lasts++;
        end
      end
      held_valid = out_valid && !(out_ready && clk_en);
      held_win   = out_window;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #10;
    checkOutput("reset_out_valid", WIN'(out_valid), '0);
    checkOutput("reset_out_last", WIN'(out_last), '0);
    checkOutput("reset_out_window", out_window, '0);
    checkOutput("reset_in_ready", WIN'(in_ready), WIN'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, consumer always ready.
    mode = 0;
    applyStimulus(0, W * H - 1);
    drainAndCount("frame1", 6, 1);
    checkOutput("first_elem00", WIN'(first_win[PIX-1:0]), WIN'(24'h020100));
    checkOutput("first_elem22", WIN'(first_win[PIX*8 +: PIX]), WIN'(24'h0E0D0C));

    // Same frame with out_ready toggling and periodic clk_en stalls.
    mode = 1;
    applyStimulus(0, W * H - 1);
    drainAndCount("stall", 6, 1);

    // Two back-to-back frames; the second must not carry first-frame data.
    mode = 0;
    applyStimulus(0, W * H - 1);
    applyStimulus(100, W * H - 1);
    drainAndCount("two_frames", 12, 2);

    // Reset mid-frame while a window is pending at the output.
    mode = 2;
    applyStimulus(0, 12);
    checkOutput("pending_valid", WIN'(out_valid), WIN'(1));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", WIN'(out_valid), '0);
    checkOutput("async_reset_window", out_window, '0);
    sb.delete();
    seen  = 0;
    lasts = 0;
    mode  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    applyStimulus(50, W * H - 1);
    drainAndCount("after_reset", 6, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
